majority_vote_controller: RTL and testbench
===========================================

// Module: majority_vote_controller
// PURPOSE
//   Sequences one voting round for an N-input majority function. Opens a round on start,
//   accepts at most one vote per voter, and closes the round when every voter has voted
//   or a timeout expires. Then produces a registered majority result with a done pulse.
//   Sits between the voter interfaces and downstream logic that consumes the decision.
// PARAMETERS
//   N        3   number of voters; must be odd and >= 3
//   CNT_W    4   width of yes_count; must satisfy 2**CNT_W > N
//   TIMEOUT  16  maximum number of cycles spent in COLLECT; must be >= 1
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-high reset
//   start       in   1      opens a round; sampled only in IDLE
//   vote_valid  in   N      per-voter vote strobe
//   vote_val    in   N      per-voter vote value (1 = yes); qualified by vote_valid
//   busy        out  1      high while a round is in progress (COLLECT or DECIDE)
//   done        out  1      one-cycle pulse; result is valid from this cycle on
//   result      out  1      1 when yes_count*2 > N (absolute majority of all N voters)
//   yes_count   out  CNT_W  yes votes accepted in the current or last round
//   voted       out  N      mask of voters whose vote has been accepted
//   timed_out   out  1      last round closed by timeout with voted != all-ones
// BEHAVIOUR
//   Reset values: state=IDLE; busy, done, result, timed_out = 0; yes_count = 0;
//     voted = 0; internal timer = 0.
//   Reset mid-round: next state is IDLE, everything is cleared, and no done is issued.
//   States: IDLE -> COLLECT -> DECIDE -> IDLE. All outputs are registered.
//   IDLE:
//     - start=1 at edge E -> COLLECT.
//     - At E, clear voted, yes_count, result, timed_out and timer.
//     - busy goes high from E.
//     - vote_valid is ignored in IDLE.
//   COLLECT, at each edge:
//     - For each i with vote_valid[i] && !voted[i]: set voted[i] and add vote_val[i]
//       to yes_count. Several voters in one cycle are summed in that cycle.
//     - A repeat vote from a voter already marked in voted is ignored. Its value is
//       never re-counted.
//     - timer increments by 1.
//     - -> DECIDE when the updated voted mask is all ones, or when timer == TIMEOUT-1
//       (the TIMEOUT-th COLLECT cycle). Votes sampled on that edge are still counted.
//     - If both conditions hold on the same edge, the round is treated as all-voted
//       and timed_out=0.
//     - start is ignored while busy.
//   DECIDE, single cycle, at its edge:
//     - result <= (2*yes_count > N).
//     - timed_out <= (voted != all ones).
//     - done <= 1, busy <= 0, -> IDLE.
//     - Missing voters count as "no".
//   Latency: last vote sampled at edge T. DECIDE is active in the cycle after T.
//     done, result and busy=0 become visible after edge T+1.
//     Timeout case: done is visible TIMEOUT+1 edges after the start edge.
//   done is high for exactly one cycle. It is cleared by the next edge unconditionally.
//   result, yes_count, voted and timed_out hold their values until the next accepted start.
//   start sampled in the same cycle done is high (state IDLE) is accepted; back-to-back
//     rounds are legal.
//   yes_count never exceeds N, so no wrap occurs with legal CNT_W.
// TESTING (N=3, TIMEOUT=16)
//   1. Reset held 2 cycles with start=1 and vote_valid=111 -> all outputs 0, busy=0,
//      no done.
//   2. start; then vote_valid=111, vote_val=101 in one cycle -> done 2 edges later,
//      result=1, yes_count=2, voted=111, timed_out=0.
//   3. start; voter0 yes, then voter0 no (repeat), then voter1 no, then voter2 no ->
//      yes_count=1, result=0, and the repeat vote is ignored.
//   4. start; only voter1 votes yes, others silent -> done after TIMEOUT+1 edges,
//      voted=010, yes_count=1, result=0, timed_out=1.
//   5. start pulsed again during COLLECT -> no effect; assert start while done=1 ->
//      new round, outputs cleared, busy=1.
//   6. reset asserted mid-COLLECT with 2 votes accepted -> IDLE, yes_count=0, voted=000,
//      and no done pulse afterwards.

Source files
------------

// File: rtl/majority_vote_controller.sv
// majority_vote_controller
//   Runs one voting round for an N-input majority decision. A round opens on
//   start, takes at most one vote per voter, and closes when every voter has
//   voted or after TIMEOUT collection cycles. One decision cycle follows, which
//   registers the majority result and pulses done.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      opens a round; only looked at while idle
//   vote_valid per-voter vote strobe
//   vote_val   per-voter vote value (1 = yes), qualified by vote_valid
//   busy       high while a round is in progress (collect or decide)
//   done       one-cycle pulse; result is valid from this cycle on
//   result     1 when 2*yes_count > N (absolute majority of all N voters)
//   yes_count  yes votes accepted in the current or last round
//   voted      mask of voters whose vote has been accepted
//   timed_out  last round closed by timeout with some voter missing
//   dbg_state  current FSM state (0 idle, 1 collect, 2 decide)
//
// Handshake: a vote from voter i is taken on any edge in collect where
// vote_valid[i] is high and voted[i] is still clear; there is no ready signal,
// the voted mask tells a voter its vote has landed. Later strobes from that
// voter are dropped.

module majority_vote_controller #(
  parameter int N       = 3,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     vote_valid,
  input  logic [N-1:0]     vote_val,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic [CNT_W-1:0] yes_count,
  output logic [N-1:0]     voted,
  output logic             timed_out,
  output logic [1:0]       dbg_state
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DECIDE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_n;
  logic               r_busy, r_done, r_result, r_timed_out;
  logic [CNT_W-1:0]   r_yes_count;
  logic [N-1:0]       r_voted;
  logic [TMR_W-1:0]   r_timer;

  logic               w_busy_n, w_done_n, w_result_n, w_timed_out_n;
  logic [CNT_W-1:0]   w_yes_count_n;
  logic [N-1:0]       w_voted_n;
  logic [TMR_W-1:0]   w_timer_n;

  // Voters voting for the first time this cycle, and the mask after accepting them.
  logic [N-1:0]       w_new;
  logic [N-1:0]       w_voted_upd;
  logic               w_all_voted;
  logic               w_last_cycle;
  logic [CNT_W-1:0]   w_add;
  logic [CNT_W:0]     w_twice_yes;

  assign w_new        = vote_valid & ~r_voted;
  assign w_voted_upd  = r_voted | w_new;
  assign w_all_voted  = &w_voted_upd;
  assign w_last_cycle = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_twice_yes  = {r_yes_count, 1'b0};

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= 1'b0;
      r_timed_out <= 1'b0;
      r_yes_count <= '0;
      r_voted     <= '0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_state_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
      r_result    <= w_result_n;
      r_timed_out <= w_timed_out_n;
      r_yes_count <= w_yes_count_n;
      r_voted     <= w_voted_n;
      r_timer     <= w_timer_n;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_n = S_COLLECT;
      // All-voted and timeout on the same edge both just go to decide; the
      // decide cycle sees a full mask and so reports no timeout.
      S_COLLECT: if (w_all_voted || w_last_cycle) w_state_n = S_DECIDE;
      S_DECIDE:  w_state_n = S_IDLE;
      default:   w_state_n = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_busy_n      = r_busy;
    w_done_n      = 1'b0;
    w_result_n    = r_result;
    w_timed_out_n = r_timed_out;
    w_yes_count_n = r_yes_count;
    w_voted_n     = r_voted;
    w_timer_n     = r_timer;
    w_add         = '0;
    for (int i = 0; i < N; i++) begin
      w_add = w_add + CNT_W'(w_new[i] & vote_val[i]);
    end
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_busy_n      = 1'b1;
          w_result_n    = 1'b0;
          w_timed_out_n = 1'b0;
          w_yes_count_n = '0;
          w_voted_n     = '0;
          w_timer_n     = '0;
        end
      end
      S_COLLECT: begin
        w_voted_n     = w_voted_upd;
        w_yes_count_n = r_yes_count + w_add;
        w_timer_n     = r_timer + TMR_W'(1);
      end
      S_DECIDE: begin
        w_result_n    = (w_twice_yes > (CNT_W + 1)'(N));
        w_timed_out_n = (r_voted != {N{1'b1}});
        w_done_n      = 1'b1;
        w_busy_n      = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign timed_out = r_timed_out;
  assign yes_count = r_yes_count;
  assign voted     = r_voted;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_majority_vote_controller.sv
// tb_majority_vote_controller
//   Bench for majority_vote_controller with N=3, TIMEOUT=16. Each round is
//   described as a table of per-cycle vote strobes; a reference model works out
//   from the voting rules which votes count, how many collection cycles the
//   round lasts and what the decision must be.

module tb_majority_vote_controller;

  localparam int N       = 3;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [N-1:0]     vote_valid;
  logic [N-1:0]     vote_val;
  logic             busy;
  logic             done;
  logic             result;
  logic [CNT_W-1:0] yes_count;
  logic [N-1:0]     voted;
  logic             timed_out;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;

  // Per-cycle stimulus for the collection window of one round.
  logic [N-1:0] cyc_valid [TIMEOUT];
  logic [N-1:0] cyc_val   [TIMEOUT];
  bit           noise_start = 0;

  majority_vote_controller #(.N(N), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .vote_valid (vote_valid),
    .vote_val   (vote_val),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .yes_count  (yes_count),
    .voted      (voted),
    .timed_out  (timed_out),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_vectors();
    for (int c = 0; c < TIMEOUT; c++) begin
      cyc_valid[c] = '0;
      cyc_val[c]   = '0;
    end
  endtask

  task automatic random_vectors(input int sparsity);
    for (int c = 0; c < TIMEOUT; c++) begin
      cyc_valid[c] = '0;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, sparsity) == 0) cyc_valid[c][i] = 1'b1;
      cyc_val[c] = N'($urandom_range(0, (1 << N) - 1));
    end
  endtask

  // Runs one round from the current vector table and checks it against the model.
  // chained: start was already raised in the previous round's done cycle.
  // chain_next: raise start in this round's done cycle and return immediately.
  task automatic do_round(input bit chained, input bit chain_next, input string name);
    logic [N-1:0] m_voted;
    int           m_yes;
    int           m_ncol;
    bit           m_to;
    bit           m_res;
    bit           seen;
    int           k_done;

    // Model: first vote per voter wins, round ends at full mask or TIMEOUT cycles.
    m_voted = '0;
    m_yes   = 0;
    m_ncol  = 0;
    for (int c = 0; c < TIMEOUT; c++) begin
      m_ncol = c + 1;
      for (int i = 0; i < N; i++) begin
        if (cyc_valid[c][i] && !m_voted[i]) begin
          m_voted[i] = 1'b1;
          m_yes      = m_yes + int'(cyc_val[c][i]);
        end
      end
      if (m_voted == {N{1'b1}}) break;
    end
    m_to  = (m_voted != {N{1'b1}});
    m_res = (2 * m_yes > N);

    if (!chained) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || voted !== '0 || yes_count !== '0 ||
        result !== 1'b0 || timed_out !== 1'b0) begin
      errors++;
      $display("FAIL %s open: busy=%b done=%b voted=%b yes=%0d res=%b to=%b, required 1 0 000 0 0 0",
               name, busy, done, voted, yes_count, result, timed_out);
    end

    seen   = 0;
    k_done = 0;
    for (int k = 1; k <= TIMEOUT + 4 && !seen; k++) begin
      @(negedge clk);
      if (k - 1 < TIMEOUT) begin
        vote_valid = cyc_valid[k-1];
        vote_val   = cyc_val[k-1];
      end else begin
        vote_valid = '0;
        vote_val   = '0;
      end
      start = noise_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen   = 1;
        k_done = k;
      end else if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy: busy=%b at edge %0d, required 1", name, busy, k);
      end
    end
    start      = 1'b0;
    vote_valid = '0;
    vote_val   = '0;

    checks++;
    if (!seen || k_done != m_ncol + 1) begin
      errors++;
      $display("FAIL %s latency: done at edge %0d (seen=%0d), required edge %0d",
               name, k_done, seen, m_ncol + 1);
    end
    checks++;
    if (result !== m_res || yes_count !== CNT_W'(m_yes) || voted !== m_voted ||
        timed_out !== m_to || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s decision: res=%b yes=%0d voted=%b to=%b busy=%b, required %b %0d %b %b 0",
               name, result, yes_count, voted, timed_out, busy, m_res, m_yes, m_voted, m_to);
    end

    if (chain_next) begin
      start = 1'b1;
    end else begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== m_res ||
          yes_count !== CNT_W'(m_yes) || voted !== m_voted || timed_out !== m_to) begin
        errors++;
        $display("FAIL %s hold: done=%b busy=%b res=%b yes=%0d voted=%b to=%b, required 0 0 %b %0d %b %b",
                 name, done, busy, result, yes_count, voted, timed_out, m_res, m_yes, m_voted, m_to);
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    start      = 1'b1;
    vote_valid = '1;
    vote_val   = '1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 1'b0 || yes_count !== '0 ||
          voted !== '0 || timed_out !== 1'b0) begin
        errors++;
        $display("FAIL reset: busy=%b done=%b res=%b yes=%0d voted=%b to=%b, required all 0",
                 busy, done, result, yes_count, voted, timed_out);
      end
    end
    @(negedge clk);
    reset      = 1'b0;
    start      = 1'b0;
    vote_valid = '0;
    vote_val   = '0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || voted !== '0) begin
      errors++;
      $display("FAIL reset_release: busy=%b done=%b voted=%b, required 0 0 000", busy, done, voted);
    end
  endtask

  task automatic test_all_at_once();
    clear_vectors();
    cyc_valid[0] = 3'b111;
    cyc_val[0]   = 3'b101;
    do_round(0, 0, "all_at_once");
  endtask

  task automatic test_repeat_vote();
    clear_vectors();
    cyc_valid[0] = 3'b001; cyc_val[0] = 3'b001;
    cyc_valid[1] = 3'b001; cyc_val[1] = 3'b000;
    cyc_valid[2] = 3'b010; cyc_val[2] = 3'b000;
    cyc_valid[3] = 3'b100; cyc_val[3] = 3'b000;
    do_round(0, 0, "repeat_vote");
  endtask

  task automatic test_timeout();
    clear_vectors();
    cyc_valid[3] = 3'b010; cyc_val[3] = 3'b010;
    do_round(0, 0, "timeout");
  endtask

  task automatic test_last_cycle_vote();
    // Final voter arrives on the TIMEOUT-th cycle: counted, and not a timeout.
    clear_vectors();
    cyc_valid[0]           = 3'b011; cyc_val[0]           = 3'b010;
    cyc_valid[TIMEOUT - 1] = 3'b100; cyc_val[TIMEOUT - 1] = 3'b100;
    do_round(0, 0, "last_cycle_vote");
  endtask

  task automatic test_start_ignored_and_back_to_back();
    noise_start = 1;
    clear_vectors();
    cyc_valid[2] = 3'b001; cyc_val[2] = 3'b001;
    cyc_valid[7] = 3'b110; cyc_val[7] = 3'b111;
    do_round(0, 1, "start_noise");
    noise_start = 0;
    random_vectors(3);
    do_round(1, 1, "back_to_back_a");
    random_vectors(1);
    do_round(1, 0, "back_to_back_b");
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      random_vectors(int'($urandom_range(1, 8)));
      do_round(0, 0, "random");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    vote_valid = 3'b011;
    vote_val   = 3'b011;
    @(posedge clk); #1;
    checks++;
    if (yes_count !== 4'd2 || voted !== 3'b011) begin
      errors++;
      $display("FAIL reset_mid_pre: yes=%0d voted=%b, required 2 011", yes_count, voted);
    end
    @(negedge clk);
    reset      = 1'b1;
    vote_valid = 3'b111;
    vote_val   = 3'b111;
    @(posedge clk); #1;
    checks++;
    if (yes_count !== '0 || voted !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: yes=%0d voted=%b busy=%b done=%b, required 0 000 0 0",
               yes_count, voted, busy, done);
    end
    @(negedge clk);
    reset      = 1'b0;
    vote_valid = '0;
    vote_val   = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet: done=%b busy=%b at cycle %0d, required 0 0", done, busy, c);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    vote_valid = '0;
    vote_val   = '0;
    test_reset();
    test_all_at_once();
    test_repeat_vote();
    test_timeout();
    test_last_cycle_vote();
    test_start_ignored_and_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
